// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_pkg                                                          |
// | Shared defaults, FSM state type and fill-counter width helper.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_det_pkg;

    localparam int DEF_SYM_W   = 3;
    localparam int DEF_SEQ_LEN = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    function automatic int fill_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_history.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_history                                                      |
// | Symbol history shift register (oldest in low slice) + fill counter.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_det_history #(
    parameter int SYM_W   = 3,
    parameter int SEQ_LEN = 4,
    parameter int FILL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     shift_i,
    input  logic                     fill_clr_i,
    input  logic [SYM_W-1:0]         data_i,
    output logic [SEQ_LEN*SYM_W-1:0] shifted_o,
    output logic [FILL_W-1:0]        fill_o
);

    localparam int               HIST_W   = SEQ_LEN * SYM_W;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Newest symbol enters at the top so slice 0 always holds the oldest.
    assign shifted_o = {data_i, hist_q[HIST_W-1:SYM_W]};
    assign fill_o    = fill_q;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = shifted_o;
            if (fill_clr_i) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detector_param                                                   |
// | Programmable-pattern sequence detector with saturating match count.  |
// | Optional SEQ_DET_MASK_EN adds a per-bit don't-care mask.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_valid_i,
    input  logic [SYM_W-1:0]         data_i,
    input  logic [SEQ_LEN*SYM_W-1:0] pattern_i,
`ifdef SEQ_DET_MASK_EN
    input  logic [SEQ_LEN*SYM_W-1:0] pattern_mask_i,
`endif
    input  logic                     pattern_load_i,
    input  logic                     overlap_en_i,
    input  logic                     count_clr_i,
    output logic                     sequence_found_o,
    output logic [CNT_W-1:0]         match_count_o
);

    localparam int HIST_W = SEQ_LEN * SYM_W;
    localparam int FILL_W = fill_width(SEQ_LEN);

    state_e             state_q, state_d;
    logic [HIST_W-1:0]  pattern_q;
    logic               found_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [HIST_W-1:0]  w_shifted;
    logic [HIST_W-1:0]  w_diff;
    logic [FILL_W-1:0]  w_fill;
    logic               w_accept;
    logic               w_last_fill;
    logic               w_match;

    seq_det_history #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN),
        .FILL_W  (FILL_W)
    ) u_history (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (pattern_load_i),
        .shift_i    (w_accept),
        .fill_clr_i (w_match & ~overlap_en_i),
        .data_i     (data_i),
        .shifted_o  (w_shifted),
        .fill_o     (w_fill)
    );

    // A load in the same cycle discards the incoming symbol.
    assign w_accept    = data_valid_i & ~pattern_load_i;
    assign w_last_fill = (w_fill == FILL_W'(SEQ_LEN - 1));

`ifdef SEQ_DET_MASK_EN
    logic [HIST_W-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (pattern_load_i) begin
            mask_q <= pattern_mask_i;
        end
    end

    assign w_diff = (w_shifted ^ pattern_q) & ~mask_q;
`else
    assign w_diff = w_shifted ^ pattern_q;
`endif

    assign w_match = w_accept & ((state_q == ST_ARMED) | w_last_fill) & (w_diff == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (w_accept && w_last_fill && !(w_match && !overlap_en_i)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (pattern_load_i || (w_match && !overlap_en_i)) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (count_clr_i) begin
            count_d = CNT_W'(w_match);
        end else if (w_match && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            pattern_q <= '0;
            found_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            found_q   <= w_match;
            count_q   <= count_d;
            if (pattern_load_i) begin
                pattern_q <= pattern_i;
            end
        end
    end

    assign sequence_found_o = found_q;
    assign match_count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_detector_param                                                |
// | Scoreboard bench with a queue-based reference model.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_detector_param;

    localparam int SW = 3;
    localparam int SL = 4;
    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef logic [SW-1:0] sym_t;
    typedef struct packed {
        logic          f;
        logic [CW-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             data_valid = 1'b0;
    logic [SW-1:0]    data = '0;
    logic [SL*SW-1:0] pattern = '0;
`ifdef SEQ_DET_MASK_EN
    logic [SL*SW-1:0] pattern_mask = '0;
`endif
    logic             pattern_load = 1'b0;
    logic             overlap_en = 1'b0;
    logic             count_clr = 1'b0;
    logic             sequence_found;
    logic [CW-1:0]    match_count;

    int n_checks = 0;
    int n_errors = 0;

    sym_t hist[$];
    sym_t m_pat[SL];
    sym_t m_msk[SL];
    int   m_cnt;
    exp_t exp_q[$];

    seq_detector_param #(
        .SYM_W   (SW),
        .SEQ_LEN (SL),
        .CNT_W   (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_valid_i     (data_valid),
        .data_i           (data),
        .pattern_i        (pattern),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask_i   (pattern_mask),
`endif
        .pattern_load_i   (pattern_load),
        .overlap_en_i     (overlap_en),
        .count_clr_i      (count_clr),
        .sequence_found_o (sequence_found),
        .match_count_o    (match_count)
    );

    always #5 clk = ~clk;

    function automatic logic [SL*SW-1:0] pk(input int a, input int b, input int c, input int d);
        return {SW'(d), SW'(c), SW'(b), SW'(a)};
    endfunction

    // Reference: the last SL accepted symbols since the last clear, compared as a list.
    task automatic model_step();
        bit match = 0;
        if (pattern_load) begin
            for (int i = 0; i < SL; i++) begin
                m_pat[i] = pattern[i*SW +: SW];
`ifdef SEQ_DET_MASK_EN
                m_msk[i] = pattern_mask[i*SW +: SW];
`else
                m_msk[i] = '0;
`endif
            end
            hist.delete();
        end else if (data_valid) begin
            hist.push_back(data);
            if (hist.size() > SL) void'(hist.pop_front());
            if (hist.size() == SL) begin
                match = 1;
                for (int i = 0; i < SL; i++)
                    if (((hist[i] ^ m_pat[i]) & ~m_msk[i]) != '0) match = 0;
            end
            if (match && !overlap_en) hist.delete();
        end
        if (count_clr) m_cnt = match ? 1 : 0;
        else if (match && m_cnt < CNT_MAX) m_cnt++;
        exp_q.push_back('{f: match, c: CW'(m_cnt)});
    endtask

    task automatic drive(input bit v, input int d, input bit ld, input logic [SL*SW-1:0] p,
                         input bit ovl, input bit clr);
        @(negedge clk);
        data_valid   = v;
        data         = SW'(d);
        pattern_load = ld;
        pattern      = p;
        overlap_en   = ovl;
        count_clr    = clr;
        model_step();
    endtask

    task automatic idle_inputs();
        data_valid = 0; data = '0; pattern_load = 0; pattern = '0;
        overlap_en = 0; count_clr = 0;
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if (sequence_found !== 1'b0 || match_count !== '0) begin
            n_errors++;
            $display("FAIL %s: found=%0b count=%0d, want found=0 count=0", nm, sequence_found, match_count);
        end
    endtask

    // Asserts reset partway through the current cycle, dropping any pending expectation.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < SL; i++) begin m_pat[i] = '0; m_msk[i] = '0; end
        m_cnt = 0;
        #1;
        check_zero("reset_outputs");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        model_step();
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (sequence_found !== e.f) begin
                n_errors++;
                $display("FAIL found @%0t: got %0b want %0b", $time, sequence_found, e.f);
            end
            n_checks++;
            if (match_count !== e.c) begin
                n_errors++;
                $display("FAIL count @%0t: got %0d want %0d", $time, match_count, e.c);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SL*SW-1:0] p1234, p1111, prnd;
        p1234 = pk(1, 2, 3, 4);
        p1111 = pk(1, 1, 1, 1);
        do_reset();

        // Basic match
        drive(0, 0, 1, p1234, 1, 0);
        for (int i = 1; i <= 4; i++) drive(1, i, 0, '0, 1, 0);
        repeat (2) drive(0, 0, 0, '0, 1, 0);

        // Overlapping vs non-overlapping runs of 1s
        drive(0, 0, 1, p1111, 1, 1);
        repeat (6) drive(1, 1, 0, '0, 1, 0);
        drive(0, 0, 1, p1111, 0, 1);
        repeat (6) drive(1, 1, 0, '0, 0, 0);

        // Valid gaps are transparent
        drive(0, 0, 1, p1234, 1, 1);
        drive(1, 1, 0, '0, 1, 0);
        drive(1, 2, 0, '0, 1, 0);
        repeat (3) drive(0, 5, 0, '0, 1, 0);
        drive(1, 3, 0, '0, 1, 0);
        drive(1, 4, 0, '0, 1, 0);

        // Reset partway through a sequence
        drive(1, 1, 0, '0, 1, 0);
        drive(1, 2, 0, '0, 1, 0);
        drive(1, 3, 0, '0, 1, 0);
        do_reset();
        drive(1, 4, 0, '0, 1, 0);
        drive(0, 0, 0, '0, 1, 0);

        // Saturation, then clear on a match cycle
        drive(0, 0, 1, p1111, 1, 0);
        repeat (12) drive(1, 1, 0, '0, 1, 0);
        drive(1, 1, 0, '0, 1, 1);
        drive(1, 1, 0, '0, 1, 0);
        drive(0, 0, 0, '0, 1, 1);

        // Load with a simultaneous valid symbol discards it
        drive(0, 0, 1, p1234, 1, 0);
        drive(1, 1, 0, '0, 1, 0);
        drive(1, 2, 0, '0, 1, 0);
        drive(1, 3, 1, p1234, 1, 0);
        drive(1, 4, 0, '0, 1, 0);
        for (int i = 1; i <= 4; i++) drive(1, i, 0, '0, 1, 0);

`ifdef SEQ_DET_MASK_EN
        pattern_mask = {SW'(0), SW'(0), {SW{1'b1}}, SW'(0)};
        drive(0, 0, 1, pk(1, 0, 3, 4), 1, 1);
        drive(1, 1, 0, '0, 1, 0);
        drive(1, 7, 0, '0, 1, 0);
        drive(1, 3, 0, '0, 1, 0);
        drive(1, 4, 0, '0, 1, 0);
        drive(1, 4, 0, '0, 1, 0);
`endif

        // Randomized traffic over a small alphabet so matches are frequent
        for (int n = 0; n < 400; n++) begin
            bit ld;
            ld = ($urandom_range(0, 39) == 0) || (n == 0);
            prnd = pk($urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2));
`ifdef SEQ_DET_MASK_EN
            if (ld) pattern_mask = ($urandom_range(0, 3) == 0) ? SL*SW'($urandom) : '0;
`endif
            drive($urandom_range(0, 3) != 0, $urandom_range(1, 2), ld, prnd,
                  $urandom_range(0, 1), $urandom_range(0, 29) == 0);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
